// File: rtl/ram_dump_pkg.sv
// Shared types for the RAM dump reader: FSM state encoding and default sizing.
package ram_dump_pkg;

  localparam int DEPTH_DEF = 65;
  localparam int CSUM_W    = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5
  } dump_state_t;

endpackage

// File: rtl/ram_addr_wrap.sv
// Address successor for a DEPTH-entry RAM: increments and wraps from DEPTH-1 back to 0.
module ram_addr_wrap #(
  parameter int DEPTH  = 65,
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] next_o
);

  assign next_o = (addr_i == ADDR_W'(DEPTH - 1)) ? '0 : addr_i + 1'b1;

endmodule

// File: rtl/ram_dump_reader.sv
// Streams a range of RamD bytes out over valid/ready through a synchronous read port.
// Optional trailing checksum beat is enabled by defining RAM_DUMP_CHECKSUM_EN.
module ram_dump_reader
  import ram_dump_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  length,
  input  logic              abort,
  input  logic              mem_gnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  dump_state_t       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  len_clamped;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              done_q;
  logic              last_data_beat;
`ifdef RAM_DUMP_CHECKSUM_EN
  logic [CSUM_W-1:0] sum_q;
  logic [CSUM_W-1:0] sum_nxt;

  assign sum_nxt = sum_q + CSUM_W'(out_data_q);
`endif

  ram_addr_wrap #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_wrap (
    .addr_i (addr_q),
    .next_o (addr_d)
  );

  assign len_clamped    = (length > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : length;
  assign last_data_beat = (remaining_q == CNT_W'(1));

  // The read strobe follows the grant combinationally so a denied cycle issues nothing.
  assign rd_en     = (state_q == RD) && mem_gnt && !abort;
  assign rd_addr   = addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef RAM_DUMP_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              addr_q      <= start_addr;
              remaining_q <= len_clamped;
`ifdef RAM_DUMP_CHECKSUM_EN
              sum_q       <= '0;
              if (len_clamped == '0) begin
                state_q     <= CSUM;
                out_data_q  <= '0;
                out_addr_q  <= '0;
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b1;
              end else begin
                state_q <= RD;
              end
`else
              if (len_clamped == '0) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= RD;
              end
`endif
            end
          end
          RD: begin
            if (mem_gnt) state_q <= WAIT;
          end
          WAIT: begin
            out_data_q  <= rd_data;
            out_addr_q  <= addr_q;
            out_valid_q <= 1'b1;
`ifdef RAM_DUMP_CHECKSUM_EN
            out_last_q  <= 1'b0;
`else
            out_last_q  <= last_data_beat;
`endif
            state_q     <= SEND;
          end
          SEND: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              remaining_q <= remaining_q - 1'b1;
              addr_q      <= addr_d;
`ifdef RAM_DUMP_CHECKSUM_EN
              sum_q       <= sum_nxt;
`endif
              if (!last_data_beat) begin
                state_q <= RD;
              end else begin
`ifdef RAM_DUMP_CHECKSUM_EN
                // Checksum beat is preloaded here so it appears with no gap.
                state_q     <= CSUM;
                out_data_q  <= DATA_W'(sum_nxt);
                out_addr_q  <= '0;
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b1;
`else
                state_q <= DONE;
                done_q  <= 1'b1;
`endif
              end
            end
          end
          CSUM: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= DONE;
              done_q      <= 1'b1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_dump_reader.sv
// Scoreboard bench for ram_dump_reader: reference model queues expected beats, monitor compares.
module tb_ram_dump_reader;

  localparam int DEPTH = 65;
`ifdef RAM_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] a;
    logic       l;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] start_addr = '0;
  logic [6:0] length = '0;
  logic       abort = 1'b0;
  logic       mem_gnt = 1'b1;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [7:0] out_addr;
  logic       out_last;
  logic       busy;
  logic       done;

  ram_dump_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .abort      (abort),
    .mem_gnt    (mem_gnt),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [DEPTH];
  beat_t      exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int beats_seen = 0;
  int last_cyc = 0;
  int gnt_mode = 0;
  int rdy_mode = 0;
  int gnt_stall = 0;
  int rdy_stall = 0;
  logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pd = '0, pa = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM read port model: data the cycle after the strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en && rd_addr < 8'(DEPTH)) rd_data <= ram[rd_addr];
  end

  // Grant / ready drivers
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (gnt_mode)
        1:       mem_gnt = $urandom_range(0, 1) == 1;
        2:       if (busy && gnt_stall < 4) begin mem_gnt = 1'b0; gnt_stall++; end
                 else mem_gnt = 1'b1;
        default: mem_gnt = 1'b1;
      endcase
      case (rdy_mode)
        1:       out_ready = $urandom_range(0, 2) != 0;
        2:       if (out_valid && beats_seen == 1 && rdy_stall < 5) begin out_ready = 1'b0; rdy_stall++; end
                 else out_ready = 1'b1;
        3:       out_ready = (beats_seen == 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard pops, hold stability, read-strobe legality, done timing
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
        continue;
      end
      if (rd_en) begin
        rd_cnt++;
        check("rd_en_needs_gnt", 32'(mem_gnt), 32'd1);
      end
      if (pv && !pr && out_valid) begin
        check("hold_data", 32'(out_data), 32'(pd));
        check("hold_addr", 32'(out_addr), 32'(pa));
        check("hold_last", 32'(out_last), 32'(pl));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got data %0h addr %0h, expected no beat", out_data, out_addr);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(e.d));
          check("beat_addr", 32'(out_addr), 32'(e.a));
          check("beat_last", 32'(out_last), 32'(e.l));
        end
        beats_seen++;
        if (out_last) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (beats_seen > 0) check("done_after_last", 32'(cyc - last_cyc), 32'd1);
      end
      pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr; pl = out_last;
    end
  end

  // Reference model: the bytes a dump of (sa, len) must produce
  task automatic model_push(input int sa, input int len);
    int n;
    int a;
    logic [7:0] s;
    n = (len > DEPTH) ? DEPTH : len;
    s = 8'h00;
    for (int k = 0; k < n; k++) begin
      a = (sa + k) % DEPTH;
      exp_q.push_back('{d: ram[a], a: 8'(a), l: (k == n - 1) && !CSUM});
      s = s + ram[a];
    end
    if (CSUM) exp_q.push_back('{d: s, a: 8'h00, l: 1'b1});
  endtask

  task automatic issue_start(input int sa, input int len);
    beats_seen = 0;
    gnt_stall  = 0;
    rdy_stall  = 0;
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = 8'(sa);
    length     = 7'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_dump(input int sa, input int len, input int gm, input int rm, input bit chk_lat);
    int n;
    int rd0;
    int dn0;
    int to;
    n = (len > DEPTH) ? DEPTH : len;
    gnt_mode = gm;
    rdy_mode = rm;
    model_push(sa, len);
    rd0 = rd_cnt;
    dn0 = done_cnt;
    issue_start(sa, len);
    if (chk_lat) begin
      @(negedge clk);
      check("lat_rd_en_c1", 32'(rd_en), 32'd1);
      check("lat_rd_addr_c1", 32'(rd_addr), 32'(sa));
      @(negedge clk);
      check("lat_valid_c2", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_valid_c3", 32'(out_valid), 32'd1);
    end
    to = 0;
    while (done_cnt == dn0 && to < 3000) begin
      @(negedge clk);
      to++;
    end
    check("done_seen", 32'(done_cnt - dn0), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("rd_count", 32'(rd_cnt - rd0), 32'(n));
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_addr"}, 32'(out_addr), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int to;
    int dn0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i + 1);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    run_dump(0, 4, 0, 0, 1'b1);
    run_dump(63, 3, 0, 0, 1'b0);
    run_dump(0, 6, 0, 2, 1'b0);
    run_dump(2, 3, 2, 0, 1'b0);
    run_dump(0, 0, 0, 0, 1'b0);
    run_dump(10, 100, 0, 0, 1'b0);

    // Abort while the second beat is waiting for ready
    gnt_mode = 0;
    rdy_mode = 3;
    model_push(5, 6);
    dn0 = done_cnt;
    issue_start(5, 6);
    to = 0;
    while (!(out_valid && beats_seen == 1) && to < 100) begin
      @(negedge clk);
      to++;
    end
    check("abort_reached_beat2", 32'(beats_seen), 32'd1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_en", 32'(rd_en), 32'd0);
    repeat (10) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - dn0), 32'd0);
    exp_q.delete();
    rdy_mode = 0;

    // Reset in the middle of a long dump
    model_push(0, 20);
    issue_start(0, 20);
    to = 0;
    while (beats_seen < 2 && to < 100) begin
      @(negedge clk);
      to++;
    end
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;

    // Randomized dumps over random RAM contents, grant and ready
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom_range(0, 255));
      run_dump($urandom_range(0, DEPTH - 1), $urandom_range(0, 80), 1, 1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
